// File: rtl/anc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : anc_pkg
// Brief    : Shared widths, saturation limits and sequencer states for the
//            ANC microphone front end.
// Revision : 1.0 - initial release
// ============================================================================
package anc_pkg;

    localparam int AUD_W   = 16;
    localparam int ACC_W   = 18;
    localparam int Q_SHIFT = 15;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// ============================================================================
// Module   : sat_clamp
// Brief    : Signed width reduction with saturation to the output range.
// Revision : 1.0 - initial release
// ============================================================================
module sat_clamp #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [OUT_W-1:0] C_OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] C_OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // The value fits when every bit above the output sign bit copies it.
    logic [IN_W-OUT_W:0] w_upper;
    assign w_upper = din[IN_W-1:OUT_W-1];

    always_comb begin
        dout = din[OUT_W-1:0];
        if (!((&w_upper) || !(|w_upper))) begin
            dout = din[IN_W-1] ? C_OUT_MIN : C_OUT_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mic_dc_block.sv
`default_nettype none
// ============================================================================
// Module   : mic_dc_block
// Brief    : Three-channel DC-blocking high-pass on a single shared multiplier,
//            y[n] = x[n] - x[n-1] + (A*y[n-1]) >>> 15, saturated to 16 bits.
// Revision : 1.0 - initial release
// ============================================================================
module mic_dc_block
    import anc_pkg::*;
#(
    parameter int COEF_A = 32604,
    parameter int NCH    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_strobe,
    input  logic signed [AUD_W-1:0] ref_i,
    input  logic signed [AUD_W-1:0] en1_i,
    input  logic signed [AUD_W-1:0] en2_i,
    input  logic                    bypass,
    output logic signed [AUD_W-1:0] ref_o,
    output logic signed [AUD_W-1:0] en1_o,
    output logic signed [AUD_W-1:0] en2_o,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic signed [AUD_W:0] C_COEF = {1'b0, AUD_W'(COEF_A)};
    localparam logic [1:0]            C_LAST = 2'(NCH - 1);

    state_t                  r_state;
    logic [1:0]              r_ch;
    logic                    r_byp;
    logic signed [31:0]      r_prod;
    logic signed [AUD_W-1:0] r_x_in   [NCH];
    logic signed [AUD_W-1:0] r_x_prev [NCH];
    logic signed [AUD_W-1:0] r_y_prev [NCH];

    logic signed [ACC_W-1:0] w_sum;
    logic signed [AUD_W-1:0] w_sat;

    assign w_sum = ACC_W'(r_x_in[r_ch]) - ACC_W'(r_x_prev[r_ch])
                 + ACC_W'(r_prod >>> Q_SHIFT);

    sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (AUD_W)
    ) u_sat (
        .din  (w_sum),
        .dout (w_sat)
    );

    // busy spans acceptance through the out_valid cycle, so it also gates new strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ch      <= 2'd0;
            r_byp     <= 1'b0;
            r_prod    <= '0;
            ref_o     <= '0;
            en1_o     <= '0;
            en2_o     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_x_in[i]   <= '0;
                r_x_prev[i] <= '0;
                r_y_prev[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (sample_strobe && busy) begin
                overrun <= 1'b1;
            end
            if (out_valid) begin
                busy <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (sample_strobe && !busy) begin
                        r_x_in[0] <= ref_i;
                        r_x_in[1] <= en1_i;
                        r_x_in[2] <= en2_i;
                        r_byp     <= bypass;
                        r_ch      <= 2'd0;
                        busy      <= 1'b1;
                        r_state   <= MUL;
                    end
                end
                MUL: begin
                    r_prod  <= 32'(r_y_prev[r_ch]) * 32'(C_COEF);
                    r_state <= ACC;
                end
                ACC: begin
                    r_y_prev[r_ch] <= w_sat;
                    r_x_prev[r_ch] <= r_x_in[r_ch];
                    if (r_ch == C_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_ch    <= r_ch + 2'd1;
                        r_state <= MUL;
                    end
                end
                DONE: begin
                    ref_o     <= r_byp ? r_x_in[0] : r_y_prev[0];
                    en1_o     <= r_byp ? r_x_in[1] : r_y_prev[1];
                    en2_o     <= r_byp ? r_x_in[2] : r_y_prev[2];
                    out_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mic_dc_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic_dc_block
// Brief    : Randomised self-checking bench with an integer reference model;
//            instance 0 uses the default pole, instance 1 uses COEF_A = 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mic_dc_block;

    localparam int C_COEF [2] = '{32604, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               strobe    [2];
    logic               byp       [2];
    logic signed [15:0] ref_in    [2];
    logic signed [15:0] en1_in    [2];
    logic signed [15:0] en2_in    [2];
    logic signed [15:0] ref_out   [2];
    logic signed [15:0] en1_out   [2];
    logic signed [15:0] en2_out   [2];
    logic               valid_out [2];
    logic               busy_out  [2];
    logic               ovr_out   [2];

    mic_dc_block #(.COEF_A(32604), .NCH(3)) dut (
        .clk(clk), .rst_n(rst_n), .sample_strobe(strobe[0]),
        .ref_i(ref_in[0]), .en1_i(en1_in[0]), .en2_i(en2_in[0]), .bypass(byp[0]),
        .ref_o(ref_out[0]), .en1_o(en1_out[0]), .en2_o(en2_out[0]),
        .out_valid(valid_out[0]), .busy(busy_out[0]), .overrun(ovr_out[0])
    );

    mic_dc_block #(.COEF_A(0), .NCH(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_strobe(strobe[1]),
        .ref_i(ref_in[1]), .en1_i(en1_in[1]), .en2_i(en2_in[1]), .bypass(byp[1]),
        .ref_o(ref_out[1]), .en1_o(en1_out[1]), .en2_o(en2_out[1]),
        .out_valid(valid_out[1]), .busy(busy_out[1]), .overrun(ovr_out[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: previous input/output per instance and channel.
    int m_xp  [2][3];
    int m_yp  [2][3];
    int m_exp [2][3];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor_q15(input int p);
        int q;
        q = p / 32768;
        if (p < 0 && q * 32768 != p) q = q - 1;
        return q;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        case ($urandom_range(0, 3))
            0:       v = -16'sd32768;
            1:       v = 16'sd32767;
            default: v = 16'($urandom);
        endcase
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                m_xp[d][c] = 0; m_yp[d][c] = 0; m_exp[d][c] = 0;
            end
    endtask

    task automatic model_step(input int d, input int xr, input int xe1, input int xe2, input bit bp);
        int x [3];
        int y;
        x[0] = xr; x[1] = xe1; x[2] = xe2;
        for (int c = 0; c < 3; c++) begin
            y = clamp16(x[c] - m_xp[d][c] + floor_q15(C_COEF[d] * m_yp[d][c]));
            m_xp[d][c]  = x[c];
            m_yp[d][c]  = y;
            m_exp[d][c] = bp ? x[c] : y;
        end
    endtask

    task automatic check_outputs(input int d, input string tag);
        check({tag, "_ref"}, int'(ref_out[d]), m_exp[d][0]);
        check({tag, "_en1"}, int'(en1_out[d]), m_exp[d][1]);
        check({tag, "_en2"}, int'(en2_out[d]), m_exp[d][2]);
    endtask

    // One accepted sample: strobe, scramble the inputs afterwards, wait for out_valid.
    task automatic do_sample(input int d, input int xr, input int xe1, input int xe2, input bit bp);
        int k;
        @(posedge clk); #1;
        ref_in[d] = 16'(xr); en1_in[d] = 16'(xe1); en2_in[d] = 16'(xe2);
        byp[d] = bp; strobe[d] = 1'b1;
        model_step(d, xr, xe1, xe2, bp);
        @(posedge clk); #1;
        strobe[d] = 1'b0; byp[d] = ~bp;
        ref_in[d] = 16'($urandom); en1_in[d] = 16'($urandom); en2_in[d] = 16'($urandom);
        k = 1;
        while (!valid_out[d] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, 8);
        check("busy_at_valid", int'(busy_out[d]), 1);
        check_outputs(d, "sample");
    endtask

    int first_v;
    int n_valid;

    initial begin
        for (int d = 0; d < 2; d++) begin
            strobe[d] = 1'b0; byp[d] = 1'b0;
            ref_in[d] = '0; en1_in[d] = '0; en2_in[d] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_outputs(d, "reset");
            check("reset_valid", int'(valid_out[d]), 0);
            check("reset_busy", int'(busy_out[d]), 0);
            check("reset_ovr", int'(ovr_out[d]), 0);
        end
        rst_n = 1'b1;

        // Constant ref decays toward zero; outputs hold across the idle gap.
        do_sample(0, 1000, 0, 0, 0);
        check("dc_ref_1", int'(ref_out[0]), 1000);
        repeat (92) @(posedge clk);
        #1 check("hold_ref", int'(ref_out[0]), 1000);
        do_sample(0, 1000, 0, 0, 0);
        check("dc_ref_2", int'(ref_out[0]), 994);
        repeat (92) @(posedge clk);
        do_sample(0, 1000, 0, 0, 0);
        check("dc_ref_3", int'(ref_out[0]), 989);

        // Full-scale step saturates instead of wrapping.
        do_sample(0, 1000, -32768, 0, 0);
        check("step_en1_lo", int'(en1_out[0]), -32768);
        do_sample(0, 1000, 32767, 0, 0);
        check("step_en1_hi", int'(en1_out[0]), 32767);
        check("step_en2", int'(en2_out[0]), 0);
        check("no_ovr_yet", int'(ovr_out[0]), 0);

        // Second strobe three cycles in is dropped and flagged.
        @(posedge clk); #1;
        ref_in[0] = 16'sd300; en1_in[0] = 16'sd40; en2_in[0] = -16'sd70;
        byp[0] = 1'b0; strobe[0] = 1'b1;
        model_step(0, 300, 40, -70, 1'b0);
        first_v = 0; n_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            strobe[0] = (k == 3);
            if (k == 3) begin
                ref_in[0] = 16'sd9999; en1_in[0] = 16'sd9999; en2_in[0] = 16'sd9999;
            end
            if (k == 1) check("busy_t1", int'(busy_out[0]), 1);
            if (k == 9) check("busy_t9", int'(busy_out[0]), 0);
            if (valid_out[0]) begin
                n_valid++;
                if (first_v == 0) first_v = k;
            end
        end
        check("ovr_valid_count", n_valid, 1);
        check("ovr_valid_cycle", first_v, 8);
        check_outputs(0, "ovr");
        check("ovr_sticky", int'(ovr_out[0]), 1);

        // Reset in the middle of a sequence aborts it.
        @(posedge clk); #1;
        ref_in[0] = 16'sd777; strobe[0] = 1'b1;
        @(posedge clk); #1;
        strobe[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(0, "midrst");
        check("midrst_busy", int'(busy_out[0]), 0);
        check("midrst_ovr", int'(ovr_out[0]), 0);
        n_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (valid_out[0]) n_valid++;
        end
        check("midrst_no_valid", n_valid, 0);
        do_sample(0, 500, 0, 0, 0);
        check("after_rst_ref", int'(ref_out[0]), 500);

        // Bypass passes raw data while the filter history keeps moving.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        do_sample(0, 1234, -5, 77, 1);
        check("byp_ref", int'(ref_out[0]), 1234);
        check("byp_en1", int'(en1_out[0]), -5);
        check("byp_en2", int'(en2_out[0]), 77);
        do_sample(0, 1234, -5, 77, 0);
        check("post_byp_ref", int'(ref_out[0]), 1227);

        // Random traffic at the minimum accepted spacing on both builds.
        for (int n = 0; n < 300; n++)
            do_sample(0, rnd16(), rnd16(), rnd16(), ($urandom_range(0, 7) == 0));
        for (int n = 0; n < 3000; n++)
            do_sample(1, rnd16(), rnd16(), rnd16(), 1'b0);
        check("final_ovr0", int'(ovr_out[0]), 0);
        check("final_ovr1", int'(ovr_out[1]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
